// File: rtl/sdram_is42s16160b_responder.sv
// IS42S16160B-style SDRAM device responder: decodes the command bus, tracks per-bank rows and timers,
// stores write data and returns reads after the programmed CAS latency while flagging driver violations.
module sdram_is42s16160b_responder #(
    parameter int ROW_BITS = 4,
    parameter int COL_BITS = 4,
    parameter int RCD      = 3,
    parameter int RP       = 3,
    parameter int RC       = 10
) (
    input  logic        SDRAM_CLK_IN,
    input  logic        reset,
    input  logic [3:0]  DRAM_CMD,
    input  logic [12:0] DRAM_ADDR,
    input  logic [1:0]  DRAM_BA,
    input  logic        DRAM_CKE,
    input  logic [1:0]  DRAM_DQM,
    input  logic [15:0] dq_in,
    output logic [15:0] dq_out,
    output logic        dq_oe,
    output logic        init_done,
    output logic [3:0]  bank_open,
    output logic [15:0] ref_cnt,
    output logic        err_init,
    output logic        err_protocol,
    output logic        err_timing
);
    localparam int IDX_W = 2 + ROW_BITS + COL_BITS;
    localparam logic [4:0] RCD_T = 5'(RCD);
    localparam logic [4:0] RP_T  = 5'(RP);
    localparam logic [4:0] RC_T  = 5'(RC);

    typedef enum logic [3:0] {
        CMD_MRS = 4'b0000, CMD_REF = 4'b0001, CMD_PRE = 4'b0010, CMD_ACT = 4'b0011,
        CMD_WR  = 4'b0100, CMD_RD  = 4'b0101, CMD_BST = 4'b0110, CMD_NOP = 4'b0111
    } cmd_e;

    function automatic logic [4:0] sat_inc(input logic [4:0] v);
        return (v == 5'd31) ? v : v + 5'd1;
    endfunction

    function automatic logic [15:0] apply_dqm(input logic [15:0] w, input logic [1:0] m);
        return {m[1] ? 8'h00 : w[15:8], m[0] ? 8'h00 : w[7:0]};
    endfunction

    logic [15:0]         mem [1 << IDX_W];
    logic [3:0]          bank_open_q, bank_open_d, last_act_q, last_act_d;
    logic [ROW_BITS-1:0] row_q [4];
    logic [ROW_BITS-1:0] row_d [4];
    logic [4:0]          tmr_q [4];
    logic [4:0]          tmr_d [4];
    logic [4:0]          gtmr_q, gtmr_d;
    logic [2:0]          cl_q, cl_d;
    logic                init_done_q, init_done_d;
    logic [15:0]         ref_cnt_q, ref_cnt_d;
    logic                err_init_q, err_init_d, err_protocol_q, err_protocol_d, err_timing_q, err_timing_d;
    logic [15:0]         rd_p0_q, rd_p0_d, rd_p1_q, rd_p1_d, dq_out_q, dq_out_d;
    logic                vld_p0_q, vld_p0_d, vld_p1_q, vld_p1_d, dq_oe_q, dq_oe_d;
    logic                rd_go, wr_en, cmd_live, unused_addr;
    logic [IDX_W-1:0]    idx;
    logic [15:0]         rd_word;

    assign unused_addr = ^DRAM_ADDR;
    assign idx      = {DRAM_BA, row_q[DRAM_BA], DRAM_ADDR[COL_BITS-1:0]};
    assign rd_word  = apply_dqm(mem[idx], DRAM_DQM);
    assign cmd_live = DRAM_CKE && !DRAM_CMD[3] && DRAM_CMD[2:0] != 3'b111 && DRAM_CMD[2:0] != 3'b110;

    always_comb begin
        bank_open_d    = bank_open_q;
        last_act_d     = last_act_q;
        cl_d           = cl_q;
        init_done_d    = init_done_q;
        ref_cnt_d      = ref_cnt_q;
        err_init_d     = err_init_q;
        err_protocol_d = err_protocol_q;
        err_timing_d   = err_timing_q;
        gtmr_d         = sat_inc(gtmr_q);
        rd_go          = 1'b0;
        wr_en          = 1'b0;
        for (int b = 0; b < 4; b++) begin
            row_d[b] = row_q[b];
            tmr_d[b] = sat_inc(tmr_q[b]);
        end
        // Timers hold edges elapsed since the last ACT/PRE (bank) or REF (global).
        if (cmd_live) begin
            if (gtmr_q < RC_T) err_timing_d = 1'b1;
            case (cmd_e'(DRAM_CMD))
                CMD_ACT: begin
                    if (!init_done_q) err_init_d = 1'b1;
                    if (bank_open_q[DRAM_BA]) begin
                        err_protocol_d = 1'b1;
                    end else begin
                        if (last_act_q[DRAM_BA] ? (tmr_q[DRAM_BA] < RC_T) : (tmr_q[DRAM_BA] < RP_T))
                            err_timing_d = 1'b1;
                        bank_open_d[DRAM_BA] = 1'b1;
                        last_act_d[DRAM_BA]  = 1'b1;
                        tmr_d[DRAM_BA]       = 5'd1;
                        row_d[DRAM_BA]       = DRAM_ADDR[ROW_BITS-1:0];
                    end
                end
                CMD_RD, CMD_WR: begin
                    if (!init_done_q) err_init_d = 1'b1;
                    if (!bank_open_q[DRAM_BA]) begin
                        err_protocol_d = 1'b1;
                    end else begin
                        if (tmr_q[DRAM_BA] < RCD_T) err_timing_d = 1'b1;
                        rd_go = (DRAM_CMD == CMD_RD);
                        wr_en = (DRAM_CMD == CMD_WR);
                        if (DRAM_ADDR[10]) begin
                            bank_open_d[DRAM_BA] = 1'b0;
                            last_act_d[DRAM_BA]  = 1'b0;
                            tmr_d[DRAM_BA]       = 5'd1;
                        end
                    end
                end
                CMD_PRE: begin
                    for (int b = 0; b < 4; b++) begin
                        if (DRAM_ADDR[10] || DRAM_BA == 2'(b)) begin
                            bank_open_d[b] = 1'b0;
                            last_act_d[b]  = 1'b0;
                            tmr_d[b]       = 5'd1;
                        end
                    end
                end
                CMD_REF: begin
                    if (|bank_open_q) err_protocol_d = 1'b1;
                    ref_cnt_d = ref_cnt_q + 16'd1;
                    gtmr_d    = 5'd1;
                end
                CMD_MRS: begin
                    if (|bank_open_q || !(DRAM_ADDR[6:4] == 3'd2 || DRAM_ADDR[6:4] == 3'd3)
                        || DRAM_ADDR[2:0] != 3'b000) begin
                        err_protocol_d = 1'b1;
                    end else begin
                        cl_d        = DRAM_ADDR[6:4];
                        init_done_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        // CL=3 enters at p0, CL=2 skips straight to p1; p1 feeds the output register.
        vld_p0_d = rd_go && (cl_q == 3'd3);
        rd_p0_d  = rd_word;
        vld_p1_d = vld_p0_q;
        rd_p1_d  = rd_p0_q;
        if (rd_go && cl_q == 3'd2) begin
            vld_p1_d = 1'b1;
            rd_p1_d  = rd_word;
        end
        dq_oe_d  = vld_p1_q;
        dq_out_d = vld_p1_q ? rd_p1_q : 16'h0000;
    end

    always_ff @(posedge SDRAM_CLK_IN or posedge reset) begin
        if (reset) begin
            bank_open_q    <= '0;
            last_act_q     <= '0;
            gtmr_q         <= 5'd31;
            cl_q           <= 3'd3;
            init_done_q    <= 1'b0;
            ref_cnt_q      <= '0;
            err_init_q     <= 1'b0;
            err_protocol_q <= 1'b0;
            err_timing_q   <= 1'b0;
            vld_p0_q       <= 1'b0;
            vld_p1_q       <= 1'b0;
            dq_oe_q        <= 1'b0;
            dq_out_q       <= '0;
            for (int b = 0; b < 4; b++) tmr_q[b] <= 5'd31;
        end else begin
            bank_open_q    <= bank_open_d;
            last_act_q     <= last_act_d;
            gtmr_q         <= gtmr_d;
            cl_q           <= cl_d;
            init_done_q    <= init_done_d;
            ref_cnt_q      <= ref_cnt_d;
            err_init_q     <= err_init_d;
            err_protocol_q <= err_protocol_d;
            err_timing_q   <= err_timing_d;
            vld_p0_q       <= vld_p0_d;
            vld_p1_q       <= vld_p1_d;
            dq_oe_q        <= dq_oe_d;
            dq_out_q       <= dq_out_d;
            for (int b = 0; b < 4; b++) tmr_q[b] <= tmr_d[b];
        end
    end

    always_ff @(posedge SDRAM_CLK_IN) begin
        rd_p0_q <= rd_p0_d;
        rd_p1_q <= rd_p1_d;
        for (int b = 0; b < 4; b++) row_q[b] <= row_d[b];
        if (wr_en) begin
            if (!DRAM_DQM[0]) mem[idx][7:0]  <= dq_in[7:0];
            if (!DRAM_DQM[1]) mem[idx][15:8] <= dq_in[15:8];
        end
    end

    assign dq_out       = dq_out_q;
    assign dq_oe        = dq_oe_q;
    assign init_done    = init_done_q;
    assign bank_open    = bank_open_q;
    assign ref_cnt      = ref_cnt_q;
    assign err_init     = err_init_q;
    assign err_protocol = err_protocol_q;
    assign err_timing   = err_timing_q;
endmodule

// File: tb/tb_sdram_is42s16160b_responder.sv
// Directed bench for the SDRAM responder: init, round trip, DQM, timing, protocol and reset cases.
module tb_sdram_is42s16160b_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  cmd;
    logic [12:0] addr;
    logic [1:0]  ba;
    logic        cke;
    logic [1:0]  dqm;
    logic [15:0] dq_in;
    logic [15:0] dq_out;
    logic        dq_oe;
    logic        init_done;
    logic [3:0]  bank_open;
    logic [15:0] ref_cnt;
    logic        err_init, err_protocol, err_timing;
    int          total = 0;
    int          bad = 0;

    localparam logic [3:0] C_MRS = 4'b0000, C_REF = 4'b0001, C_PRE = 4'b0010, C_ACT = 4'b0011,
                           C_WR = 4'b0100, C_RD = 4'b0101, C_NOP = 4'b0111;

    always #5 clk = ~clk;

    sdram_is42s16160b_responder dut (
        .SDRAM_CLK_IN(clk), .reset(reset), .DRAM_CMD(cmd), .DRAM_ADDR(addr), .DRAM_BA(ba),
        .DRAM_CKE(cke), .DRAM_DQM(dqm), .dq_in(dq_in), .dq_out(dq_out), .dq_oe(dq_oe),
        .init_done(init_done), .bank_open(bank_open), .ref_cnt(ref_cnt), .err_init(err_init),
        .err_protocol(err_protocol), .err_timing(err_timing)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] errs();
        return {err_init, err_protocol, err_timing};
    endfunction

    task automatic issue(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a,
                         input logic [1:0] m, input logic [15:0] d);
        cmd = c; ba = b; addr = a; dqm = m; dq_in = d;
        @(posedge clk);
        #1;
        cmd = C_NOP; ba = 2'd0; addr = 13'd0; dqm = 2'b00; dq_in = 16'h0;
    endtask

    task automatic nop(input int n);
        repeat (n) issue(C_NOP, 2'd0, 13'd0, 2'b00, 16'h0);
    endtask

    task automatic reset_mrs(input logic [12:0] mode);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        issue(C_MRS, 2'd0, mode, 2'b00, 16'h0);
    endtask

    initial begin
        reset = 1'b1; cke = 1'b1; cmd = C_NOP; addr = 13'd0; ba = 2'd0; dqm = 2'b00; dq_in = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_oe", {31'd0, dq_oe}, 32'd0);
        check("rst_dq", {16'd0, dq_out}, 32'd0);
        check("rst_init", {31'd0, init_done}, 32'd0);
        check("rst_bank", {28'd0, bank_open}, 32'd0);
        check("rst_ref", {16'd0, ref_cnt}, 32'd0);
        check("rst_err", {29'd0, errs()}, 32'd0);
        reset = 1'b0;

        issue(C_PRE, 2'd0, 13'h400, 2'b00, 16'h0);
        repeat (8) begin
            issue(C_REF, 2'd0, 13'd0, 2'b00, 16'h0);
            nop(9);
        end
        issue(C_MRS, 2'd0, 13'h030, 2'b00, 16'h0);
        check("init_done", {31'd0, init_done}, 32'd1);
        check("init_ref", {16'd0, ref_cnt}, 32'd8);
        check("init_err", {29'd0, errs()}, 32'd0);

        issue(C_ACT, 2'd2, 13'd5, 2'b00, 16'h0);
        check("act_open", {28'd0, bank_open}, 32'h4);
        nop(3);
        issue(C_WR, 2'd2, 13'h407, 2'b00, 16'hA5C3);
        check("ap_close", {28'd0, bank_open}, 32'h0);
        nop(2);
        issue(C_ACT, 2'd2, 13'd5, 2'b00, 16'h0);
        nop(3);
        issue(C_RD, 2'd2, 13'd7, 2'b00, 16'h0);
        check("rd_n0_oe", {31'd0, dq_oe}, 32'd0);
        nop(1);
        check("rd_n1_oe", {31'd0, dq_oe}, 32'd0);
        nop(1);
        check("rd_n2_oe", {31'd0, dq_oe}, 32'd1);
        check("rd_n2_dq", {16'd0, dq_out}, 32'hA5C3);
        nop(1);
        check("rd_n3_oe", {31'd0, dq_oe}, 32'd0);
        check("rt_err", {29'd0, errs()}, 32'd0);

        issue(C_WR, 2'd2, 13'd3, 2'b00, 16'h1234);
        issue(C_WR, 2'd2, 13'd3, 2'b01, 16'hFFFF);
        issue(C_RD, 2'd2, 13'd3, 2'b00, 16'h0);
        issue(C_RD, 2'd2, 13'd3, 2'b10, 16'h0);
        nop(1);
        check("dqm00_oe", {31'd0, dq_oe}, 32'd1);
        check("dqm00_dq", {16'd0, dq_out}, 32'hFF34);
        nop(1);
        check("dqm10_oe", {31'd0, dq_oe}, 32'd1);
        check("dqm10_dq", {16'd0, dq_out}, 32'h0034);
        nop(1);
        check("dqm_end_oe", {31'd0, dq_oe}, 32'd0);
        check("dqm_err", {29'd0, errs()}, 32'd0);

        reset_mrs(13'h030);
        issue(C_ACT, 2'd2, 13'd5, 2'b00, 16'h0);
        nop(1);
        issue(C_RD, 2'd2, 13'd7, 2'b00, 16'h0);
        check("rcd_err", {29'd0, errs()}, 32'b001);
        nop(2);
        check("rcd_oe", {31'd0, dq_oe}, 32'd1);
        check("rcd_dq", {16'd0, dq_out}, 32'hA5C3);

        reset_mrs(13'h030);
        issue(C_ACT, 2'd2, 13'd5, 2'b00, 16'h0);
        nop(2);
        issue(C_PRE, 2'd2, 13'd0, 2'b00, 16'h0);
        nop(1);
        check("rp_pre_err", {29'd0, errs()}, 32'd0);
        issue(C_ACT, 2'd2, 13'd5, 2'b00, 16'h0);
        check("rp_err", {29'd0, errs()}, 32'b001);

        reset_mrs(13'h030);
        issue(C_RD, 2'd0, 13'd7, 2'b00, 16'h0);
        check("rdcl_err", {29'd0, errs()}, 32'b010);
        nop(2);
        check("rdcl_oe", {31'd0, dq_oe}, 32'd0);

        reset_mrs(13'h030);
        issue(C_ACT, 2'd1, 13'd0, 2'b00, 16'h0);
        check("ref_pre_err", {29'd0, errs()}, 32'd0);
        issue(C_REF, 2'd0, 13'd0, 2'b00, 16'h0);
        check("refopen_err", {29'd0, errs()}, 32'b010);
        check("refopen_cnt", {16'd0, ref_cnt}, 32'd1);

        reset_mrs(13'h020);
        check("cl2_err", {29'd0, errs()}, 32'd0);
        issue(C_MRS, 2'd0, 13'h050, 2'b00, 16'h0);
        check("mrs5_err", {29'd0, errs()}, 32'b010);
        check("mrs5_init", {31'd0, init_done}, 32'd1);
        issue(C_ACT, 2'd2, 13'd5, 2'b00, 16'h0);
        nop(3);
        issue(C_RD, 2'd2, 13'd7, 2'b00, 16'h0);
        nop(1);
        check("cl2_oe", {31'd0, dq_oe}, 32'd1);
        check("cl2_dq", {16'd0, dq_out}, 32'hA5C3);
        nop(1);
        check("cl2_end_oe", {31'd0, dq_oe}, 32'd0);

        reset_mrs(13'h030);
        issue(C_ACT, 2'd2, 13'd5, 2'b00, 16'h0);
        nop(3);
        issue(C_RD, 2'd2, 13'd7, 2'b00, 16'h0);
        nop(1);
        reset = 1'b1;
        #1;
        check("mid_oe", {31'd0, dq_oe}, 32'd0);
        check("mid_bank", {28'd0, bank_open}, 32'd0);
        check("mid_err", {29'd0, errs()}, 32'd0);
        check("mid_init", {31'd0, init_done}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("mid_oe2", {31'd0, dq_oe}, 32'd0);
        nop(1);
        check("mid_oe3", {31'd0, dq_oe}, 32'd0);
        issue(C_ACT, 2'd0, 13'd1, 2'b00, 16'h0);
        check("noinit_err", {29'd0, errs()}, 32'b100);
        check("noinit_bank", {28'd0, bank_open}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sdram_is42s16160b_responder.md
Name: sdram_is42s16160b_responder

Overview:
- Cycle-accurate, synthesizable SDRAM device responder. It sits at the far end of the controller's command bus: the on-FPGA driver in loopback/debug builds talks to it instead of a real IS42S16160B.
- Decodes CS/RAS/CAS/WE commands and keeps per-bank open-row state.
- Stores write data in a small on-chip array and returns read data after the programmed CAS latency.
- Flags init, protocol and timing violations so driver bugs surface in hardware and simulation.

Parameters:
- ROW_BITS, 4, low row-address bits used for storage indexing.
- COL_BITS, 4, low column-address bits used for storage indexing.
- RCD, 3, minimum cycles from ACT to READ/WRITE in the same bank.
- RP, 3, minimum cycles from PRE to ACT in the same bank.
- RC, 10, minimum cycles from ACT to ACT in the same bank, and from REF to any non-NOP command.

Ports:
- SDRAM_CLK_IN  in  1  Single clock; all logic on the rising edge.
- reset  in  1  Asynchronous, active-high reset.
- DRAM_CMD  in  4  {CS_N,RAS_N,CAS_N,WE_N}.
- DRAM_ADDR  in  13  Row, column or mode word; A10 is the all-bank / auto-precharge bit.
- DRAM_BA  in  2  Bank select.
- DRAM_CKE  in  1  Clock enable; low means the command is ignored.
- DRAM_DQM  in  2  Byte masks; bit0 masks DQ[7:0], bit1 masks DQ[15:8].
- dq_in  in  16  Write data, sampled with the WRITE command.
- dq_out  out  16  Read data.
- dq_oe  out  1  High while dq_out carries valid read data.
- init_done  out  1  Set by the first legal MRS.
- bank_open  out  4  Per-bank row-open status.
- ref_cnt  out  16  Count of accepted REF commands; wraps.
- err_init, err_protocol, err_timing  out  1 each  Sticky violation flags.

Behaviour:
- Reset values (async on reset high): dq_out=0, dq_oe=0, init_done=0, bank_open=0, ref_cnt=0, all err_*=0.
  - Read pipeline flushed; CL=3; bank timers saturated so no timing errors follow reset.
  - Storage array is not cleared.
- Command decode, evaluated only when DRAM_CKE=1:
  - CS_N=1 (DESL) and 0111 (NOP): no action.
  - BST (0110): ignored.
- Bank timers:
  - Per-bank 5-bit counters, saturating at 31. ACT and PRE reset the addressed bank's counter; PRE-all (A10=1) resets all four.
  - One global 5-bit counter is reset by REF.
- ACT (0011):
  - bank open -> err_protocol, no change.
  - timer < RP after PRE, or < RC after previous ACT -> err_timing, but the bank is still opened.
  - Otherwise bank_open[BA]=1 and the row is latched.
- READ (0101) / WRITE (0100):
  - bank closed -> err_protocol, no access, no dq_oe.
  - timer < RCD -> err_timing, access still performed.
  - Storage index = {BA, row[ROW_BITS-1:0], ADDR[COL_BITS-1:0]}.
  - WRITE: updates only bytes whose DQM bit is 0.
  - READ sampled at edge n: dq_out/dq_oe update at edge n+CL-1 and are held exactly one cycle, so data is valid at edge n+CL. Bytes whose DQM bit was 1 at edge n read as 0x00.
  - Back-to-back READs every cycle are legal; the pipeline is CL deep.
  - A WRITE in the same cycle as a read return is allowed; the return still uses the stored word captured at the READ edge.
  - A10=1: auto-precharge. The bank closes after the access and its timer resets as for PRE.
- PRE (0010):
  - A10=1 closes all banks; A10=0 closes BA only.
  - PRE to an already-closed bank is legal.
- REF (0001):
  - any bank open -> err_protocol.
  - global timer < RC -> err_timing.
  - ref_cnt increments in all cases.
- MRS (0000):
  - any bank open -> err_protocol, mode unchanged.
  - Otherwise CL=A[6:4] and init_done=1.
  - A[6:4] not 2 or 3, or A[2:0]!=000 (burst length must be 1) -> err_protocol, mode unchanged, init_done unchanged.
- Init check: ACT, READ or WRITE while init_done=0 -> err_init. The command is still processed as above.
- Multiple violations in one cycle set every applicable flag. Flags clear only on reset.
- Reset asserted mid-read: dq_oe drops immediately and the pending returns are discarded.

Test Plan:
- Init sequence: PRE A10=1, 8x (REF + 9 NOP), MRS 0x030 -> init_done=1, ref_cnt=8, CL=3, no err_*.
- Write/read round trip:
  - ACT BA=2 row 5, 3 NOP, WRITE col 7 A10=1 with dq_in=0xA5C3, DQM=00 -> bank_open[2]=0 one cycle later.
  - Wait RP, ACT, 3 NOP, READ col 7 at edge n -> dq_oe=1 only between edges n+2 and n+3, dq_out=0xA5C3.
- DQM masking: WRITE 0xFFFF with DQM=01 over stored 0x1234 -> READ with DQM=00 returns 0xFF34; same READ with DQM=10 returns 0x0034.
- Timing: READ 2 cycles after ACT -> err_timing=1, data still returned; ACT to the same bank 5 cycles after the first ACT (bank precharged) -> err_timing=1.
- Protocol: READ to a closed bank -> err_protocol=1, dq_oe stays 0; REF with bank 1 open -> err_protocol=1, ref_cnt increments; MRS A[6:4]=5 -> err_protocol=1, CL unchanged.
- Reset and init check:
  - Assert reset one cycle after a READ -> dq_oe=0, bank_open=0, err_*=0.
  - Then ACT before MRS -> err_init=1.
